// File: rtl/input_player.sv
// Stimulus player: per-channel word buffers loaded in IDLE, replayed in lockstep from a BC0,
// followed by a one-cycle GO marker on channel 0 or a re-arm for looped replay.
//
// state | meaning
// IDLE  | buffers writable, clear/arm accepted
// ARMED | waiting for BC0, length latched
// PLAY  | issuing one read per cycle (frozen while hold)
// GO    | single cycle, GO marker enters the output pipe
// DONE  | outputs idle, arm replays, clear returns to IDLE
module input_player #(
    parameter int          N_CH    = 6,
    parameter int          WIDTH   = 36,
    parameter int          ADDR_W  = 8,
    parameter int          EVT_LEN = 64,
    parameter logic [63:0] GO_WORD = 64'hACE,
    localparam int         CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    BC0,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    clear,
    input  logic                    arm,
    input  logic                    loop_en,
    input  logic                    hold,
    output logic [N_CH*WIDTH-1:0]   dout,
    output logic [N_CH-1:0]         dout_valid,
    output logic                    evt_start,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int FILL_W = ADDR_W + 1;
    localparam int WIN_W  = (EVT_LEN > 1) ? $clog2(EVT_LEN) : 1;

    typedef enum logic [2:0] {IDLE, ARMED, PLAY, GO, DONE} state_t;

    state_t             state;
    logic [FILL_W-1:0]  fill [N_CH];
    logic [FILL_W-1:0]  len;
    logic [FILL_W-1:0]  rp;
    logic [FILL_W-1:0]  max_fill;
    logic [WIN_W-1:0]   win;

    logic [WIDTH-1:0]   mem   [N_CH][DEPTH];
    logic [WIDTH-1:0]   ram_q [N_CH];

    logic [N_CH-1:0]    s1_valid;
    logic               s1_first;
    logic               s1_go;
    logic               s1_done;

    logic               issue;
    logic               advance;
    logic               ch_ok;
    logic               wr_ok;

    always_comb begin
        max_fill = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (fill[c] > max_fill)
                max_fill = fill[c];
        end
    end

    assign issue   = (state == PLAY) && !hold;
    assign advance = !((state == PLAY) && hold);
    assign ch_ok   = int'(wr_ch) < N_CH;
    assign wr_ok   = (state == IDLE) && wr_en && !clear && ch_ok;
    assign busy    = (state != IDLE);

    // Buffer RAMs: one write port (load), one registered read port (playback).
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (wr_ok && wr_ch == CH_W'(c) && fill[c] != FILL_W'(DEPTH))
                mem[c][fill[c][ADDR_W-1:0]] <= wr_data;
            if (issue)
                ram_q[c] <= mem[c][rp[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            len      <= '0;
            rp       <= '0;
            win      <= '0;
            overflow <= 1'b0;
            for (int c = 0; c < N_CH; c++)
                fill[c] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        overflow <= 1'b0;
                        for (int c = 0; c < N_CH; c++)
                            fill[c] <= '0;
                    end else if (wr_ok) begin
                        for (int c = 0; c < N_CH; c++) begin
                            if (wr_ch == CH_W'(c)) begin
                                if (fill[c] == FILL_W'(DEPTH))
                                    overflow <= 1'b1;
                                else
                                    fill[c] <= fill[c] + FILL_W'(1);
                            end
                        end
                    end
                    if (arm) begin
                        len   <= max_fill;
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (BC0) begin
                        rp  <= '0;
                        win <= '0;
                        if (len != '0)
                            state <= PLAY;
                        else if (!loop_en)
                            state <= GO;
                    end
                end
                PLAY: begin
                    if (!hold) begin
                        rp  <= rp + FILL_W'(1);
                        win <= (win == WIN_W'(EVT_LEN - 1)) ? '0 : win + WIN_W'(1);
                        if (rp == len - FILL_W'(1))
                            state <= loop_en ? ARMED : GO;
                    end
                end
                GO: state <= DONE;
                DONE: begin
                    if (clear) begin
                        state <= IDLE;
                    end else if (arm) begin
                        len   <= max_fill;
                        state <= ARMED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage output pipe (RAM register, then output register); both stages freeze on hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= '0;
            s1_first   <= 1'b0;
            s1_go      <= 1'b0;
            s1_done    <= 1'b0;
            dout       <= '0;
            dout_valid <= '0;
            evt_start  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= s1_done;
            if (advance) begin
                for (int c = 0; c < N_CH; c++)
                    s1_valid[c] <= (state == PLAY) && (rp < fill[c]);
                s1_first <= (state == PLAY) && (win == '0);
                s1_go    <= (state == GO);
                s1_done  <= (state == DONE);

                for (int c = 0; c < N_CH; c++) begin
                    if (c == 0 && s1_go)
                        dout[c*WIDTH +: WIDTH] <= WIDTH'(GO_WORD);
                    else if (s1_valid[c])
                        dout[c*WIDTH +: WIDTH] <= ram_q[c];
                    else
                        dout[c*WIDTH +: WIDTH] <= '0;
                end
                dout_valid <= s1_valid | N_CH'(s1_go);
                evt_start  <= s1_first;
            end else begin
                evt_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_input_player.sv
// Directed bench for input_player: per-cycle expectation tables for playback runs plus
// hand-written sequences for overflow, loop and asynchronous reset.
module tb_input_player;

    localparam int          N_CH    = 6;
    localparam int          WIDTH   = 36;
    localparam int          ADDR_W  = 4;
    localparam int          EVT_LEN = 4;
    localparam int          DEPTH   = 16;
    localparam logic [63:0] GO_WORD = 64'hACE;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  BC0;
    logic                  wr_en;
    logic [2:0]            wr_ch;
    logic [WIDTH-1:0]      wr_data;
    logic                  clear;
    logic                  arm;
    logic                  loop_en;
    logic                  hold;
    logic [N_CH*WIDTH-1:0] dout;
    logic [N_CH-1:0]       dout_valid;
    logic                  evt_start;
    logic                  busy;
    logic                  done;
    logic                  overflow;

    always #5 clk = ~clk;

    input_player #(
        .N_CH(N_CH), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .EVT_LEN(EVT_LEN), .GO_WORD(GO_WORD)
    ) dut (
        .clk(clk), .reset(reset), .BC0(BC0), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .clear(clear), .arm(arm), .loop_en(loop_en), .hold(hold),
        .dout(dout), .dout_valid(dout_valid), .evt_start(evt_start),
        .busy(busy), .done(done), .overflow(overflow)
    );

    typedef struct {
        bit bc0;
        bit hold;
        int k;      // word index expected on dout, -1 for none
        bit go;
        bit evt;
        bit busy;
        bit done;
    } vec_t;

    vec_t vecs[$];
    int   exp_fill[N_CH];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [WIDTH-1:0] word_of(input int c, input int k);
        return WIDTH'((c + 1) * (1 << 20) + (k + 1) * 16 + 3);
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int ch, input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_ch   = 3'(ch);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic load_fills();
        for (int c = 0; c < N_CH; c++)
            for (int k = 0; k < exp_fill[c]; k++)
                write_word(c, word_of(c, k));
    endtask

    task automatic push(input bit bc0, input bit hd, input int k, input bit go, input bit evt,
                        input bit dn);
        vec_t v;
        v.bc0 = bc0; v.hold = hd; v.k = k; v.go = go; v.evt = evt; v.busy = 1'b1; v.done = dn;
        vecs.push_back(v);
    endtask

    // One non-loop run of len words; hold sampled high at edges hs..hs+hl-1 after BC0.
    task automatic build_play(input int len, input int hs, input int hl);
        int  kk;
        int  k;
        bit  held;
        for (int i = 0; i <= len + hl + 4; i++) begin
            held = (hl > 0) && (i >= hs) && (i < hs + hl);
            if (hl > 0 && i >= hs)
                kk = held ? hs - 3 : i - 2 - hl;
            else
                kk = i - 2;
            k = (kk >= 0 && kk < len) ? kk : -1;
            push(i == 0, held, k, i == len + 2 + hl,
                 (k >= 0) && (k % EVT_LEN == 0) && !held, i >= len + 3 + hl);
        end
    endtask

    task automatic run_vecs(input string tag);
        vec_t                  v;
        logic [N_CH*WIDTH-1:0] ed;
        logic [N_CH-1:0]       ev;
        for (int i = 0; i < vecs.size(); i++) begin
            v    = vecs[i];
            BC0  = v.bc0;
            hold = v.hold;
            tick();
            ed = '0;
            ev = '0;
            for (int c = 0; c < N_CH; c++) begin
                if (v.go && c == 0) begin
                    ed[0 +: WIDTH] = WIDTH'(GO_WORD);
                    ev[0] = 1'b1;
                end else if (v.k >= 0 && v.k < exp_fill[c]) begin
                    ed[c*WIDTH +: WIDTH] = word_of(c, v.k);
                    ev[c] = 1'b1;
                end
            end
            check($sformatf("%s.%0d dout", tag, i), dout, ed);
            check($sformatf("%s.%0d dout_valid", tag, i), dout_valid, ev);
            check($sformatf("%s.%0d evt_start", tag, i), evt_start, v.evt);
            check($sformatf("%s.%0d busy", tag, i), busy, v.busy);
            check($sformatf("%s.%0d done", tag, i), done, v.done);
        end
        BC0  = 1'b0;
        hold = 1'b0;
        vecs.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; BC0 = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
        clear = 1'b0; arm = 1'b0; loop_en = 1'b0; hold = 1'b0;
        tick();
        tick();
        check("reset dout", dout, '0);
        check("reset dout_valid", dout_valid, '0);
        check("reset evt_start", evt_start, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset overflow", overflow, 1'b0);
        reset = 1'b0;
        tick();

        // Uneven fills, invalid channels ignored, plain run ending in GO/DONE.
        exp_fill = '{3, 5, 0, 1, 8, 2};
        load_fills();
        write_word(6, 36'hFFFF);
        write_word(7, 36'hEEEE);
        pulse_arm();
        check("armed busy", busy, 1'b1);
        check("armed done", done, 1'b0);
        build_play(8, 0, 0);
        run_vecs("play");

        // Re-arm from DONE with fills kept; hold while word 4 is on dout.
        pulse_arm();
        build_play(8, 7, 3);
        run_vecs("hold");

        // Overflow on a single channel.
        pulse_clear();
        pulse_clear();
        exp_fill = '{0, DEPTH, 0, 0, 0, 0};
        for (int k = 0; k < DEPTH + 2; k++) begin
            write_word(1, word_of(1, k));
            if (k == DEPTH - 1)
                check("overflow after DEPTH writes", overflow, 1'b0);
            if (k == DEPTH)
                check("overflow after DEPTH+1 writes", overflow, 1'b1);
        end
        pulse_arm();
        build_play(DEPTH, 0, 0);
        run_vecs("ovf");
        pulse_clear();
        check("overflow kept leaving DONE", overflow, 1'b1);
        pulse_clear();
        check("overflow cleared", overflow, 1'b0);
        exp_fill = '{0, 0, 0, 0, 0, 0};
        pulse_arm();
        build_play(0, 0, 0);
        run_vecs("empty");
        pulse_clear();

        // Looped replay: BC0 during PLAY ignored, second BC0 replays, no GO marker.
        exp_fill = '{6, 2, 0, 0, 0, 4};
        load_fills();
        loop_en = 1'b1;
        pulse_arm();
        for (int i = 0; i < 20; i++) begin
            int k;
            if (i >= 2 && i <= 7)
                k = i - 2;
            else if (i >= 12 && i <= 17)
                k = i - 12;
            else
                k = -1;
            push(i == 0 || i == 3 || i == 10, 1'b0, k, 1'b0, (k >= 0) && (k % EVT_LEN == 0), 1'b0);
        end
        run_vecs("loop");

        // Asynchronous reset while word 3 is on dout.
        BC0 = 1'b1;
        tick();
        BC0 = 1'b0;
        repeat (5) tick();
        check("pre-reset word 3", dout[0 +: WIDTH], word_of(0, 3));
        #2;
        reset = 1'b1;
        #1;
        check("async reset dout", dout, '0);
        check("async reset dout_valid", dout_valid, '0);
        check("async reset evt_start", evt_start, 1'b0);
        check("async reset busy", busy, 1'b0);
        check("async reset done", done, 1'b0);
        #2;
        reset = 1'b0;
        loop_en = 1'b0;
        tick();
        exp_fill = '{0, 0, 0, 0, 0, 0};
        pulse_arm();
        build_play(0, 0, 0);
        run_vecs("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
